// File: rtl/gcd_dispatch.sv
// gcd_dispatch: FIFO-buffered job dispatcher driving a go/done GCD core with a registered valid/ready result.
// Optional watchdog enabled by GCD_DISPATCH_TIMEOUT_EN.
module gcd_dispatch #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         gcd_go,
  output logic [W-1:0] gcd_a,
  output logic [W-1:0] gcd_b,
  input  logic         gcd_done,
  input  logic [W-1:0] gcd_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_out,
  output logic         res_err,
  output logic         busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [W-1:0] a_q, b_q, res_q, res_d, hd_a, hd_b;
  logic res_valid_q, res_valid_d, push, pop, empty, full, slot_free, zero, res_wr, tmo;
  assign empty     = wr_q == rd_q;
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign slot_free = !res_valid_q || res_ready;
  assign {hd_a, hd_b} = mem_q[rd_q[AW-1:0]];
  assign zero      = (hd_a == '0) || (hd_b == '0);
  assign res_d     = (state_q == WAIT) ? (gcd_done ? gcd_out : '0) : (hd_a | hd_b);
`ifdef GCD_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic err_q;
  // done arriving on the expiry cycle still yields a normal result
  assign tmo     = (state_q == WAIT) && !gcd_done && (cnt_q == CW'(TIMEOUT - 1));
  assign res_err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ISSUE) ? '0 : (state_q == WAIT) ? cnt_q + 1'b1 : cnt_q;
      if (res_wr) err_q <= tmo;
    end
  end
`else
  assign tmo     = 1'b0;
  assign res_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    res_wr  = 1'b0;
    unique case (state_q)
      IDLE: if (!empty && slot_free) begin
        pop = 1'b1;
        res_wr = zero;
        state_d = zero ? IDLE : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (gcd_done || tmo) begin
        res_wr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    res_valid_d = res_wr || (res_valid_q && !res_ready);
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q[AW-1:0]] <= {in_a, in_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (pop && !zero) {a_q, b_q} <= {hd_a, hd_b};
      if (res_wr) res_q <= res_d;
    end
  end
  assign gcd_go    = state_q == ISSUE;
  assign gcd_a     = a_q;
  assign gcd_b     = b_q;
  assign res_valid = res_valid_q;
  assign res_out   = res_q;
  assign busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: directed table-driven bench for gcd_dispatch with a behavioural go/done GCD core.
module tb_gcd_dispatch;
  logic clk = 0, rst = 1, in_valid = 0, res_ready = 0, gcd_done;
  logic [7:0] in_a = 0, in_b = 0, gcd_out;
  logic in_ready, gcd_go, res_valid, res_err, busy;
  logic [7:0] gcd_a, gcd_b, res_out;
  int checks = 0, failures = 0, go_cnt = 0, rv_cnt = 0, ccnt;
  bit hold_done = 0, hang = 0;

  typedef struct {logic [7:0] a, b, r; int g;} vec_t;
  vec_t tv[10];

  always #5 clk = ~clk;

  gcd_dispatch #(.W(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_go(gcd_go), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_done(gcd_done), .gcd_out(gcd_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_err(res_err), .busy(busy)
  );

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // core model: done rises 5 cycles after go; pulses for one cycle or holds until the next go
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gcd_done <= 0;
      gcd_out  <= 0;
      ccnt     <= 0;
    end else if (gcd_go) begin
      gcd_done <= 0;
      ccnt     <= hang ? 0 : 4;
      gcd_out  <= gcd_f(gcd_a, gcd_b);
    end else begin
      if (ccnt != 0) ccnt <= ccnt - 1;
      if (ccnt == 1) gcd_done <= 1;
      else if (!hold_done) gcd_done <= 0;
    end
  end

  always @(negedge clk) begin
    if (gcd_go) go_cnt++;
    if (res_valid) rv_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("push_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic get(output logic [7:0] r, output logic e);
    bit ok = 0;
    r = 'x;
    e = 'x;
    for (int i = 0; i < 100; i++) begin
      if (res_valid) begin
        r = res_out;
        e = res_err;
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) check("result_timeout", 0, 1);
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    logic [7:0] r;
    logic e;
    int g0, rv0;
    tv[0] = '{12, 18, 6, 1};  tv[1] = '{7, 5, 1, 1};    tv[2] = '{8, 12, 4, 1};
    tv[3] = '{21, 14, 7, 1};  tv[4] = '{27, 36, 9, 1};  tv[5] = '{0, 9, 9, 0};
    tv[6] = '{0, 0, 0, 0};    tv[7] = '{9, 0, 9, 0};    tv[8] = '{255, 51, 51, 1};
    tv[9] = '{100, 75, 25, 1};
    repeat (2) tick();
    rst = 0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_go", gcd_go, 0);
    check("rst_busy", busy, 0);
    check("rst_res_out", res_out, 0);
    check("rst_gcd_a", gcd_a, 0);

    // single-job latency: push at N, go at N+2, res_valid at N+8
    g0 = go_cnt;
    in_a = 12; in_b = 18; in_valid = 1;
    tick();
    in_valid = 0;
    check("lat_go_n1", gcd_go, 0);
    tick();
    check("lat_go_n2", gcd_go, 1);
    check("lat_gcd_a", gcd_a, 12);
    check("lat_gcd_b", gcd_b, 18);
    tick();
    check("lat_go_n3", gcd_go, 0);
    repeat (4) tick();
    check("lat_rv_n7", res_valid, 0);
    tick();
    check("lat_rv_n8", res_valid, 1);
    check("lat_res", res_out, 6);
    check("lat_err", res_err, 0);
    check("lat_go_count", go_cnt - g0, 1);
    res_ready = 1;
    tick();
    res_ready = 0;
    check("lat_rv_cleared", res_valid, 0);
    check("lat_busy_idle", busy, 0);

    // backpressure: 4 queued + 1 in flight fills the FIFO
    for (int k = 0; k < 5; k++) push(tv[k].a, tv[k].b);
    repeat (15) tick();
    check("bp_in_ready", in_ready, 0);
    check("bp_res_valid", res_valid, 1);
    check("bp_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      get(r, e);
      check($sformatf("bp_res%0d", k), r, tv[k].r);
    end
    repeat (2) tick();
    check("bp_drained_busy", busy, 0);

    // full table one job at a time, including zero bypass
    for (int k = 0; k < 10; k++) begin
      g0 = go_cnt;
      push(tv[k].a, tv[k].b);
      get(r, e);
      check($sformatf("tv%0d_res", k), r, tv[k].r);
      check($sformatf("tv%0d_err", k), e, 0);
      check($sformatf("tv%0d_go", k), go_cnt - g0, tv[k].g);
    end

    // stale done held into the next job's ISSUE
    hold_done = 1;
    push(12, 18);
    push(7, 5);
    get(r, e);
    check("stale_res0", r, 6);
    get(r, e);
    check("stale_res1", r, 1);
    hold_done = 0;

    // reset during WAIT with 3 jobs queued
    push(8, 12);
    push(21, 14);
    push(27, 36);
    push(7, 5);
    check("rstmid_busy", busy, 1);
    check("rstmid_in_flight", gcd_a, 8);
    rv0 = rv_cnt;
    rst = 1;
    #1;
    check("rstmid_res_valid", res_valid, 0);
    check("rstmid_go", gcd_go, 0);
    check("rstmid_busy0", busy, 0);
    check("rstmid_gcd_a", gcd_a, 0);
    check("rstmid_gcd_b", gcd_b, 0);
    check("rstmid_res_out", res_out, 0);
    check("rstmid_in_ready", in_ready, 1);
    tick();
    rst = 0;
    repeat (20) tick();
    check("rstmid_no_result", rv_cnt - rv0, 0);
    check("rstmid_idle", busy, 0);
    push(21, 14);
    get(r, e);
    check("rstmid_next_res", r, 7);
    check("rstmid_next_err", e, 0);

`ifdef GCD_DISPATCH_TIMEOUT_EN
    begin
      int n = 0;
      hang = 1;
      push(12, 18);
      push(7, 5);
      while (!gcd_go && n < 50) begin tick(); n++; end
      check("tmo_go_seen", gcd_go, 1);
      n = 0;
      while (!res_valid && n < 100) begin tick(); n++; end
      check("tmo_latency", n, 17);
      check("tmo_err", res_err, 1);
      check("tmo_res", res_out, 0);
      hang = 0;
      res_ready = 1;
      tick();
      res_ready = 0;
      get(r, e);
      check("tmo_next_res", r, 1);
      check("tmo_next_err", e, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
